spi_slot_router: RTL
====================

# spi_slot_router

Clocked, parametrised SPI chip-select router between the host MCU SPI master and NUM_SLOTS expansion-slot modules on the CPLD. It replaces the purely combinational priority MISO mux with a registered grant state machine. The machine synchronises per-slot chip selects, locks one slot for the whole transaction, and detects chip-select collisions. It also conditions each slot's interrupt line back to the MCU.

## Interface
- NUM_SLOTS, 4: number of slot channels (2–8).
- SYNC_STAGES, 2: flip-flop stages on every asynchronous input (NSS, INT); minimum 2.
- GUARD_CYCLES, 4: idle clk cycles enforced after a release before the next grant; 0–15.

- clk  in  1  system clock, ≥4× host SCLK.
- rst_n  in  1  asynchronous active-low reset.
- host_nss_n  in  NUM_SLOTS  per-slot chip selects from the MCU, active-low.
- host_sclk  in  1  host SPI clock.
- host_mosi  in  1  host MOSI.
- host_miso  out  1  MISO of the granted slot; 0 when no grant.
- slot_nss_n  out  NUM_SLOTS  per-slot chip selects, registered, active-low.
- slot_sclk  out  NUM_SLOTS  host_sclk gated to the granted slot; 0 otherwise.
- slot_mosi  out  NUM_SLOTS  host_mosi gated to the granted slot; 0 otherwise.
- slot_miso  in  NUM_SLOTS  slot MISO lines.
- slot_int  in  NUM_SLOTS  slot interrupt requests, active-high.
- host_int  out  NUM_SLOTS  conditioned interrupts to the MCU.
- active_slot  out  $clog2(NUM_SLOTS)  index of the granted slot; valid while busy.
- busy  out  1  a slot is granted.
- collision  out  1  sticky collision flag.
- collision_clr  in  1  synchronous clear of collision, one-cycle pulse.

## Operation
- host_nss_n and slot_int pass through SYNC_STAGES synchronisers, giving nss_s and int_s. SCLK and MOSI are not synchronised. They are gated combinationally by the registered grant vector.
- FSM states are IDLE, GRANT and GUARD.
- IDLE: if any nss_s bit is low, grant the lowest asserted index. Set grant[idx], active_slot=idx and busy=1, then go to GRANT.
- GRANT: slot_nss_n[idx]=0. Hold until nss_s[idx] goes high. Then clear grant and busy, load the guard counter with GUARD_CYCLES, and go to GUARD. If GUARD_CYCLES=0, go directly to IDLE.
- GUARD: decrement the counter and go to IDLE at 0. No new grant is issued in GUARD.
- Collision: set collision=1 in either case below.
  - In IDLE, more than one nss_s bit is low in the same cycle.
  - In GRANT or GUARD, any nss_s bit other than the granted one is low.
- A losing chip select is never forwarded. When it is still low in IDLE, it is granted normally.
- collision_clr clears the flag unless a set condition exists in the same cycle. Set wins.
- host_miso = slot_miso[active_slot] while busy; otherwise 0.
- Reset mid-transaction: all grants drop immediately (asynchronous), slot_nss_n goes all-ones and the FSM goes to IDLE. The host must re-issue the transfer.
- Reset values:
  - slot_nss_n all 1.
  - slot_sclk, slot_mosi, host_miso all 0.
  - host_int 0, active_slot 0, busy 0, collision 0.
  - Synchronisers and guard counter 0; synchroniser NSS stages reset to 1.

## Timing
- Grant latency: host_nss_n fall to slot_nss_n fall is SYNC_STAGES+1 clk edges. The host must wait at least SYNC_STAGES+2 clk before the first SCLK edge.
- Release latency: host_nss_n rise to slot_nss_n rise is SYNC_STAGES+1 clk. SCLK gating drops in the same cycle.
- Minimum gap between transactions on any slot is SYNC_STAGES+1+GUARD_CYCLES clk.
- host_int latency: slot_int to host_int is SYNC_STAGES+1 clk, registered output.

## Configuration
- SPI_ROUTER_IRQ_LATCH_EN defined:
  - host_int[i] is sticky. It sets on an int_s[i] rising edge.
  - It clears on the cycle slot i is granted, unless a rising edge occurs in that same cycle. Set wins.
- Undefined: host_int[i] = registered int_s[i], a level passthrough.

## Test plan
- Single transfer, NUM_SLOTS=4, SYNC_STAGES=2: drive host_nss_n=4'b1101 -> slot_nss_n=4'b1101 after 3 clk, busy=1, active_slot=1. Send 8 SCLK pulses -> exactly 8 pulses on slot_sclk[1] and none elsewhere; host_miso follows slot_miso[1]. Release -> slot_nss_n=4'b1111 after 3 clk, followed by 4 guard cycles.
- Simultaneous select: host_nss_n=4'b1010 in one cycle -> slot 0 granted, collision=1. Pulse collision_clr while the condition persists -> collision remains 1.
- Late intruder: slot 2 is granted, then host_nss_n[3]=0 -> slot_nss_n[3] stays 1 and collision=1. Release slot 2 while nss[3] is held low -> slot 3 granted after guard expiry.
- Guard enforcement, GUARD_CYCLES=4: re-assert slot 0 one cycle after release -> grant is delayed until the guard counter reaches 0. Measure the gap as 3+4 clk.
- Reset mid-transfer: assert rst_n=0 during the 4th SCLK of slot 1 -> slot_nss_n=4'b1111, slot_sclk=0 and busy=0 with no clk edge. After deassert, FSM is in IDLE.
- IRQ: pulse slot_int[2] high for 5 clk.
  - With SPI_ROUTER_IRQ_LATCH_EN: host_int[2] stays 1 until slot 2 is granted.
  - Without it: host_int[2] is a 5-clk pulse delayed by 3 clk.

Source files
------------

// File: rtl/spi_slot_router.sv
// spi_slot_router: registered SPI chip-select router between one host SPI master and
// NUM_SLOTS expansion slots. Chip selects and slot interrupts are synchronised, one slot is
// locked for a whole transaction, a guard gap is enforced after each release and chip-select
// collisions raise a sticky flag.
//
// Optional feature: define SPI_ROUTER_IRQ_LATCH_EN to make host_int sticky (set on a slot
// interrupt rising edge, cleared when that slot is granted). Undefined, host_int is a
// registered level copy of the synchronised slot interrupt.
//
// Ports:
//   clk, rst_n        system clock (>= 4x host SCLK), asynchronous active-low reset
//   host_nss_n        per-slot chip selects from the MCU, active-low
//   host_sclk/mosi    host SPI clock and data, gated combinationally to the granted slot
//   host_miso         MISO of the granted slot, 0 when nothing is granted
//   slot_nss_n        registered per-slot chip selects, active-low
//   slot_sclk/mosi    gated SPI clock and data per slot
//   slot_miso         slot MISO lines
//   slot_int          slot interrupt requests, active-high
//   host_int          conditioned interrupts to the MCU
//   active_slot       index of the granted slot, valid while busy
//   busy              a slot is granted
//   collision         sticky chip-select collision flag
//   collision_clr     one-cycle synchronous clear of collision (a same-cycle set wins)

module spi_slot_router #(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SLOTS-1:0]         host_nss_n,
    input  logic                         host_sclk,
    input  logic                         host_mosi,
    output logic                         host_miso,
    output logic [NUM_SLOTS-1:0]         slot_nss_n,
    output logic [NUM_SLOTS-1:0]         slot_sclk,
    output logic [NUM_SLOTS-1:0]         slot_mosi,
    input  logic [NUM_SLOTS-1:0]         slot_miso,
    input  logic [NUM_SLOTS-1:0]         slot_int,
    output logic [NUM_SLOTS-1:0]         host_int,
    output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
    output logic                         busy,
    output logic                         collision,
    input  logic                         collision_clr
);

    localparam int unsigned IdxW = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {StIdle, StGrant, StGuard} state_e;

    // ------------------------------------------------------------------
    // Input synchronisers. NSS stages reset to 1 (deselected).
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0] nss_sync_q [SYNC_STAGES];
    logic [NUM_SLOTS-1:0] int_sync_q [SYNC_STAGES];
    logic [NUM_SLOTS-1:0] nss_s;
    logic [NUM_SLOTS-1:0] int_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                nss_sync_q[i] <= '1;
                int_sync_q[i] <= '0;
            end
        end else begin
            nss_sync_q[0] <= host_nss_n;
            int_sync_q[0] <= slot_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                nss_sync_q[i] <= nss_sync_q[i-1];
                int_sync_q[i] <= int_sync_q[i-1];
            end
        end
    end

    assign nss_s = nss_sync_q[SYNC_STAGES-1];
    assign int_s = int_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Select decode
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0] sel_vec;
    logic [NUM_SLOTS-1:0] active_mask;
    logic [IdxW-1:0]      low_idx;
    logic                 any_low;
    logic                 multi_low;
    logic                 other_low;

    assign sel_vec   = ~nss_s;
    assign any_low   = |sel_vec;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_low = |(sel_vec & (sel_vec - {{(NUM_SLOTS-1){1'b0}}, 1'b1}));

    always_comb begin
        low_idx = '0;
        // Scan downwards so the lowest asserted index is the last one written.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                low_idx = IdxW'(i);
            end
        end
    end

    // active_slot still names the released slot during GUARD, so re-selecting that same
    // slot early is not treated as a collision.
    assign active_mask = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << active_slot;
    assign other_low   = |(sel_vec & ~active_mask);

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [NUM_SLOTS-1:0] grant_q, grant_d;
    logic [IdxW-1:0]      active_q, active_d;
    logic                 busy_q, busy_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 coll_q, coll_d;
    logic                 coll_set;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            coll_q   <= coll_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        active_d = active_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        coll_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (multi_low) begin
                    coll_set = 1'b1;
                end
                if (any_low) begin
                    grant_d  = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << low_idx;
                    active_d = low_idx;
                    busy_d   = 1'b1;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                if (other_low) begin
                    coll_set = 1'b1;
                end
                if (nss_s[active_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    if (GUARD_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = 4'(GUARD_CYCLES);
                        state_d = StGuard;
                    end
                end
            end
            StGuard: begin
                if (other_low) begin
                    coll_set = 1'b1;
                end
                cnt_d = cnt_q - 4'd1;
                // The decrement that reaches zero is the last guard cycle.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (coll_set) begin
            coll_d = 1'b1;
        end else if (collision_clr) begin
            coll_d = 1'b0;
        end else begin
            coll_d = coll_q;
        end
    end

    // Output logic
    always_comb begin
        slot_nss_n  = ~grant_q;
        slot_sclk   = grant_q & {NUM_SLOTS{host_sclk}};
        slot_mosi   = grant_q & {NUM_SLOTS{host_mosi}};
        host_miso   = busy_q ? slot_miso[active_q] : 1'b0;
        active_slot = active_q;
        busy        = busy_q;
        collision   = coll_q;
    end

    // ------------------------------------------------------------------
    // Interrupt conditioning
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0] host_int_q, host_int_d;

`ifdef SPI_ROUTER_IRQ_LATCH_EN
    logic [NUM_SLOTS-1:0] int_prev_q;
    logic [NUM_SLOTS-1:0] int_rise;
    logic [NUM_SLOTS-1:0] grant_evt;

    assign int_rise  = int_s & ~int_prev_q;
    assign grant_evt = grant_d & ~grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_prev_q <= '0;
        end else begin
            int_prev_q <= int_s;
        end
    end

    // A rising edge in the grant cycle wins over the clear.
    assign host_int_d = int_rise | (host_int_q & ~grant_evt);
`else
    assign host_int_d = int_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_int_q <= '0;
        end else begin
            host_int_q <= host_int_d;
        end
    end

    assign host_int = host_int_q;

endmodule
